// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: fronts one single-port synchronous RAM (registered read
// data, 1-cycle read latency) for two requesters. Commands are granted
// round-robin. After reset, and again on clear_start, every RAM word is
// written to zero by a sweep before any command is served.
//
// Handshake: a requester raises reqN_valid with a stable command
// (we/adr/dat). The command is accepted in the cycle reqN_ready=1, and only
// then. Until it is accepted the requester must hold the command unchanged,
// because the arbiter does not latch commands. A read accepted in cycle T
// returns data in cycle T+1, with rspN_valid high for exactly that one cycle.
// Responses cannot be stalled. A write has no response: its accept is its
// completion.
module mem_port_arbiter #(
  parameter int SIZE  = 16,
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_start,
  output logic             clear_busy,
  input  logic             req0_valid,
  input  logic             req0_we,
  input  logic [SIZE-1:0]  req0_adr,
  input  logic [WIDTH-1:0] req0_dat,
  output logic             req0_ready,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_dat,
  input  logic             req1_valid,
  input  logic             req1_we,
  input  logic [SIZE-1:0]  req1_adr,
  input  logic [WIDTH-1:0] req1_dat,
  output logic             req1_ready,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_dat,
  output logic             mem_sel,
  output logic             mem_we,
  output logic [SIZE-1:0]  mem_adr,
  output logic [WIDTH-1:0] mem_dat_i,
  input  logic [WIDTH-1:0] mem_dat_o,
  output logic             state_dbg_o   // 0 = CLEAR, 1 = SERVE
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  localparam logic [SIZE-1:0] CLR_LAST = '1;

  state_t          state_q, state_d;
  logic [SIZE-1:0] clr_cnt_q, clr_cnt_d;
  logic            last_grant_q, last_grant_d;  // 1 = requester 1 was granted last
  logic            rsp0_valid_q, rsp0_valid_d;
  logic            rsp1_valid_q, rsp1_valid_d;
  logic            grant0, grant1;

  // The RAM registers its read data, so a response is the RAM output
  // qualified by a delayed read grant.
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp0_dat    = mem_dat_o;
  assign rsp1_dat    = mem_dat_o;
  assign state_dbg_o = state_q;

  // Next state, arbitration and RAM drive. While reset is high, every output
  // keeps its idle default.
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    last_grant_d = last_grant_q;
    grant0       = 1'b0;
    grant1       = 1'b0;
    clear_busy   = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    mem_sel      = 1'b0;
    mem_we       = 1'b0;
    mem_adr      = '0;
    mem_dat_i    = '0;
    if (!rst) begin
      case (state_q)
        ST_CLEAR: begin
          // One zero write per cycle. The last address is written in the
          // same cycle that hands over to SERVE.
          clear_busy = 1'b1;
          mem_sel    = 1'b1;
          mem_we     = 1'b1;
          mem_adr    = clr_cnt_q;
          if (clr_cnt_q == CLR_LAST) begin
            clr_cnt_d = '0;
            state_d   = ST_SERVE;
          end else begin
            clr_cnt_d = clr_cnt_q + 1'b1;
          end
        end
        ST_SERVE: begin
          if (clear_start) begin
            // A clear request takes priority. Nothing is granted this cycle.
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
          end else begin
            // When both requesters are valid, grant the one that did not
            // win last time.
            if (req0_valid && (!req1_valid || last_grant_q)) begin
              grant0 = 1'b1;
            end else if (req1_valid) begin
              grant1 = 1'b1;
            end
            if (grant0) begin
              req0_ready   = 1'b1;
              mem_sel      = 1'b1;
              mem_we       = req0_we;
              mem_adr      = req0_adr;
              mem_dat_i    = req0_dat;
              last_grant_d = 1'b0;
            end else if (grant1) begin
              req1_ready   = 1'b1;
              mem_sel      = 1'b1;
              mem_we       = req1_we;
              mem_adr      = req1_adr;
              mem_dat_i    = req1_dat;
              last_grant_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_CLEAR;
        end
      endcase
    end
    rsp0_valid_d = grant0 & ~req0_we;
    rsp1_valid_d = grant1 & ~req1_we;
  end

  // State register. Reset restarts the clear sweep from address 0 and drops
  // any response that is pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_CLEAR;
      clr_cnt_q    <= '0;
      last_grant_q <= 1'b1;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      last_grant_q <= last_grant_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter with SIZE=4 and WIDTH=32. It contains a
// behavioural RAM, a cycle-level reference model of the arbitration and
// clear rules, and a response scoreboard with an expected queue for each
// requester.
module tb_mem_port_arbiter;
  localparam int SIZE  = 4;
  localparam int WIDTH = 32;
  localparam int DEPTH = 1 << SIZE;

  logic             clk = 1'b0;
  logic             rst;
  logic             clear_start;
  logic             clear_busy;
  logic             req0_valid, req0_we, req0_ready, rsp0_valid;
  logic [SIZE-1:0]  req0_adr;
  logic [WIDTH-1:0] req0_dat, rsp0_dat;
  logic             req1_valid, req1_we, req1_ready, rsp1_valid;
  logic [SIZE-1:0]  req1_adr;
  logic [WIDTH-1:0] req1_dat, rsp1_dat;
  logic             mem_sel, mem_we;
  logic [SIZE-1:0]  mem_adr;
  logic [WIDTH-1:0] mem_dat_i, mem_dat_o;
  logic             state_dbg_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .clear_start(clear_start), .clear_busy(clear_busy),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_adr(req0_adr),
    .req0_dat(req0_dat), .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
    .rsp0_dat(rsp0_dat),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_adr(req1_adr),
    .req1_dat(req1_dat), .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
    .rsp1_dat(rsp1_dat),
    .mem_sel(mem_sel), .mem_we(mem_we), .mem_adr(mem_adr),
    .mem_dat_i(mem_dat_i), .mem_dat_o(mem_dat_o), .state_dbg_o(state_dbg_o)
  );

  // Behavioural single-port RAM. Writes commit at the edge. Reads are
  // registered, so read data appears one cycle after the read.
  logic [WIDTH-1:0] ram [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) ram[i] = $urandom | 32'h1;
  always @(posedge clk) begin
    if (mem_sel) begin
      if (mem_we) ram[mem_adr] <= mem_dat_i;
      else        mem_dat_o    <= ram[mem_adr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // The model describes the expected behaviour in terms of three things: a
  // clear phase that walks the addresses, a "who won last" marker and a
  // shadow copy of the memory.
  logic [WIDTH-1:0] ref_mem [DEPTH];
  logic [WIDTH-1:0] exp_q0[$], exp_q1[$];
  int               due_q0[$], due_q1[$];
  bit               m_clear = 1'b1;
  int               m_adr   = 0;
  int               m_last  = 1;
  int               g;
  logic             e_busy, e_sel, e_we, e_r0, e_r1, e_state;
  logic [WIDTH-1:0] e_adr, e_dat;

  initial for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'hDEAD_BEEF;

  always @(negedge clk) begin
    e_busy = 0; e_sel = 0; e_we = 0; e_r0 = 0; e_r1 = 0; e_adr = 0; e_dat = 0;
    e_state = m_clear ? 1'b0 : 1'b1;
    if (rst) begin
      m_clear = 1'b1; m_adr = 0; m_last = 1;
    end else if (m_clear) begin
      e_busy = 1; e_sel = 1; e_we = 1; e_adr = m_adr;
      ref_mem[m_adr] = '0;
      if (m_adr == DEPTH - 1) m_clear = 1'b0;
      m_adr = (m_adr + 1) % DEPTH;
    end else if (clear_start) begin
      m_clear = 1'b1; m_adr = 0;
    end else begin
      if (req0_valid && req1_valid) g = (m_last == 1) ? 0 : 1;
      else if (req0_valid)          g = 0;
      else if (req1_valid)          g = 1;
      else                          g = -1;
      if (g == 0) begin
        e_r0 = 1; e_sel = 1; e_we = req0_we; e_adr = req0_adr; e_dat = req0_dat;
        if (req0_we) ref_mem[req0_adr] = req0_dat;
        else begin exp_q0.push_back(ref_mem[req0_adr]); due_q0.push_back(cyc + 1); end
        m_last = 0;
      end else if (g == 1) begin
        e_r1 = 1; e_sel = 1; e_we = req1_we; e_adr = req1_adr; e_dat = req1_dat;
        if (req1_we) ref_mem[req1_adr] = req1_dat;
        else begin exp_q1.push_back(ref_mem[req1_adr]); due_q1.push_back(cyc + 1); end
        m_last = 1;
      end
    end
    check("clear_busy", clear_busy, e_busy);
    check("mem_sel", mem_sel, e_sel);
    check("mem_we", mem_we, e_we);
    check("mem_adr", mem_adr, e_adr);
    check("mem_dat_i", mem_dat_i, e_dat);
    check("req0_ready", req0_ready, e_r0);
    check("req1_ready", req1_ready, e_r1);
    if (!rst) check("state", state_dbg_o, e_state);
  end

  // ---------------- response monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (due_q0.size() > 0 && due_q0[0] == cyc) begin
      check("rsp0_valid", rsp0_valid, 1'b1);
      if (rsp0_valid) check("rsp0_dat", rsp0_dat, exp_q0[0]);
      void'(due_q0.pop_front()); void'(exp_q0.pop_front());
    end else if (rsp0_valid === 1'b1) begin
      check("rsp0_valid_spurious", rsp0_valid, 1'b0);
    end
    if (due_q1.size() > 0 && due_q1[0] == cyc) begin
      check("rsp1_valid", rsp1_valid, 1'b1);
      if (rsp1_valid) check("rsp1_dat", rsp1_dat, exp_q1[0]);
      void'(due_q1.pop_front()); void'(exp_q1.pop_front());
    end else if (rsp1_valid === 1'b1) begin
      check("rsp1_valid_spurious", rsp1_valid, 1'b0);
    end
  end

  // ---------------- driver tasks ----------------
  logic acc0, acc1;

  task automatic step();
    @(negedge clk);
    acc0 = req0_ready;
    acc1 = req1_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic we, input int adr, input logic [WIDTH-1:0] dat);
    req0_valid = v; req0_we = we; req0_adr = adr[SIZE-1:0]; req0_dat = dat;
  endtask

  task automatic drive1(input logic v, input logic we, input int adr, input logic [WIDTH-1:0] dat);
    req1_valid = v; req1_we = we; req1_adr = adr[SIZE-1:0]; req1_dat = dat;
  endtask

  task automatic idle();
    drive0(0, 0, 0, 0);
    drive1(0, 0, 0, 0);
    clear_start = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    idle();
    repeat (3) step();
    rst = 1'b0;
    repeat (18) step();                 // full clear sweep plus margin

    // Read the last address: the sweep must have zeroed it.
    drive0(1, 0, 15, 0); step(); idle(); step();

    // Write 0xA5 to address 3, then read it back in the next cycle.
    drive0(1, 1, 3, 32'hA5); step();
    drive0(1, 0, 3, 0);      step();
    idle(); repeat (2) step();

    // Reset, then both requesters valid for 4 cycles.
    rst = 1'b1; step(); rst = 1'b0;
    repeat (16) step();
    drive0(1, 0, 1, 0); drive1(1, 0, 2, 0);
    repeat (4) step();
    idle(); step();

    // Only requester 1 valid for 3 cycles, then both valid.
    drive1(1, 1, 7, 32'h1111);
    repeat (3) step();
    drive0(1, 0, 7, 0);
    repeat (2) step();
    idle(); step();

    // clear_start while both are valid. Both readies stay low through the
    // clear, and earlier data reads back as zero afterwards.
    drive0(1, 1, 5, 32'h5555); step(); idle(); step();
    drive0(1, 0, 5, 0); drive1(1, 0, 3, 0); clear_start = 1; step();
    clear_start = 0;
    repeat (18) step();
    idle(); step();

    // Reset at clear cycle 7: the sweep restarts from address 0.
    clear_start = 1; step(); clear_start = 0;
    repeat (7) step();
    rst = 1'b1; step(); rst = 1'b0;
    repeat (18) step();

    // Randomized traffic with occasional clear requests and resets.
    repeat (3000) begin
      if (!req0_valid || acc0)
        drive0($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, DEPTH - 1), $urandom);
      if (!req1_valid || acc1)
        drive1($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, DEPTH - 1), $urandom);
      clear_start = ($urandom_range(0, 199) == 0);
      rst = ($urandom_range(0, 599) == 0);
      step();
    end
    rst = 1'b0;
    idle();
    repeat (5) step();
    check("rsp0_pending", due_q0.size(), 0);
    check("rsp1_pending", due_q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM between two requesters using round-robin arbitration.
- The RAM is of the test_memory kind: sel/we/adr/dat_i in, registered dat_o, 1-cycle read latency.
- Also sequences a full-array zero-clear after reset and on command.
- Sits directly in front of the RAM instance; requesters see a valid/ready request channel and a response channel for reads.

Parameters:
- SIZE, 16, address width; RAM depth is 2^SIZE.
- WIDTH, 256, data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- clear_start  in  1  pulse; requests a full-array zero-clear.
- clear_busy  out  1  high while the clear sweep is running.
- req0_valid  in  1  requester 0 command valid.
- req0_we  in  1  requester 0: 1 = write, 0 = read.
- req0_adr  in  SIZE  requester 0 address.
- req0_dat  in  WIDTH  requester 0 write data.
- req0_ready  out  1  requester 0 command accepted this cycle.
- rsp0_valid  out  1  requester 0 read data valid.
- rsp0_dat  out  WIDTH  requester 0 read data.
- req1_valid, req1_we, req1_adr, req1_dat, req1_ready, rsp1_valid, rsp1_dat: same widths and meaning, for requester 1.
- mem_sel  out  1  RAM select.
- mem_we  out  1  RAM write enable.
- mem_adr  out  SIZE  RAM address.
- mem_dat_i  out  WIDTH  RAM write data.
- mem_dat_o  in  WIDTH  RAM registered read data.

Behaviour:
- FSM states: CLEAR, SERVE. Reset (rst=1 at posedge) forces state=CLEAR, clr_cnt=0, last_grant=1, rsp0_valid=rsp1_valid=0.
- While rst=1: mem_sel=0, req0_ready=req1_ready=0, clear_busy=0 (combinational override).
- CLEAR:
  - clear_busy=1; mem_sel=1, mem_we=1, mem_adr=clr_cnt, mem_dat_i=0.
  - clr_cnt increments each cycle.
  - When clr_cnt = 2^SIZE-1, the next state is SERVE and clr_cnt returns to 0.
  - The sweep takes exactly 2^SIZE cycles and every address 0..2^SIZE-1 is written, including the last.
  - Both ready outputs are 0; clear_start is ignored.
- SERVE:
  - clear_busy=0.
  - If clear_start=1, go to CLEAR next cycle. No grant is issued in that cycle: both ready=0 and mem_sel=0.
- Arbitration in SERVE is combinational within the cycle:
  - Only req0_valid: grant 0.
  - Only req1_valid: grant 1.
  - Both valid: grant the requester that is not last_grant.
  - Neither valid: no grant, mem_sel=0.
- On a grant:
  - reqN_ready=1 for the granted requester only.
  - mem_sel=1, mem_we=reqN_we, mem_adr=reqN_adr, mem_dat_i=reqN_dat.
  - last_grant updates to N at the posedge.
- Throughput: one command per cycle, no bubbles between back-to-back grants.
- Read response:
  - A read granted in cycle T gives rspN_valid=1 in cycle T+1 (registered), with rspN_dat=mem_dat_o (pass-through).
  - rspN_valid is high for exactly one cycle per read. There is no backpressure on responses.
- Writes produce no response; the accept (ready) is the completion.
- Read-after-write to the same address in consecutive cycles returns the new data, because the RAM write commits at the grant edge.
- mem_we/mem_adr/mem_dat_i are don't-care when mem_sel=0; drive them to 0.
- Reset mid-clear: the sweep restarts from address 0 after rst deasserts. Reset with a read in flight: that rsp_valid is dropped.
- A requester holding valid with no ready must keep its command stable; the arbiter does not latch commands.

Test Plan:
- SIZE=4. Release rst → clear_busy=1 for exactly 16 cycles, mem_adr steps 0..15 with mem_we=1 and mem_dat_i=0; then the cycle after, clear_busy=0. Reading adr 15 returns 0.
- Req0 writes 0xA5 at adr 3 in cycle T; req0 reads adr 3 in T+1 → rsp0_valid=1 in T+2 with rsp0_dat=0xA5.
- Both valid for 4 consecutive cycles after reset → grants in order 0,1,0,1; each ready is high for one of every two cycles.
- Only req1 valid for 3 cycles → req1_ready=1 for all 3 cycles; then both valid → req0 granted first (last_grant=1).
- clear_start in SERVE while both valid → both ready=0 that cycle, then 16 cycles of CLEAR with ready=0, then service resumes. Earlier-written data reads back as 0.
- Assert rst at clear cycle 7 for 1 cycle → after release, the sweep restarts at adr 0 and runs a full 16 cycles.
